// File: rtl/analysis_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : analysis_frame_ctrl_if
// Description : Sample stream, pipeline launch/return and result handshake
//               bundle for analysis_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface analysis_frame_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [511:0] fft_bus;
    logic         fft_valid;
    logic         done;
    logic [3:0]   freq_in;
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   res_freq;
    logic [7:0]   res_tag;
    logic         err_framing;
    logic         err_done;
    logic         err_timeout;

    modport slave (
        input  in_valid, in_data, in_last, done, freq_in, res_ready,
        output in_ready, fft_bus, fft_valid, res_valid, res_freq, res_tag,
               err_framing, err_done, err_timeout
    );

    modport master (
        output in_valid, in_data, in_last, done, freq_in, res_ready,
        input  in_ready, fft_bus, fft_valid, res_valid, res_freq, res_tag,
               err_framing, err_done, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/analysis_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : analysis_frame_ctrl
// Description : Frame sequencer for the 16-bin analysis pipeline: gathers 16
//               samples, launches with credits against the result FIFO and
//               returns tagged results. Watchdog enabled by
//               ANALYSIS_FRAME_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module analysis_frame_ctrl #(
    parameter int NPT       = 16,
    parameter int PIPE_LAT  = 6,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    analysis_frame_ctrl_if.slave bus
);
    localparam int         PW     = $clog2(RES_DEPTH);
    localparam int         CW     = PW + 1;
    localparam logic [3:0] C_LAST = 4'(NPT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [15:0][31:0] frame_q;
    logic              in_ready_q;
    logic              fft_valid_q;
    logic              err_framing_q;
    logic              err_done_q;

    logic [7:0]        tag_cnt_q;
    logic [7:0]        tagq_q [RES_DEPTH];
    logic [PW-1:0]     tagq_wr_q;
    logic [PW-1:0]     tagq_rd_q;
    logic [CW-1:0]     outst_q;

    logic [11:0]       fifo_q [RES_DEPTH];
    logic [PW-1:0]     fifo_wr_q;
    logic [PW-1:0]     fifo_rd_q;
    logic [CW-1:0]     fifo_cnt_q;

    logic w_accept;
    logic w_issue;
    logic w_done_ok;
    logic w_pop;
    logic w_credit;
    logic w_timeout;

    assign w_accept  = bus.in_valid & in_ready_q;
    assign w_issue   = (state_q == ISSUE);
    assign w_done_ok = bus.done & (outst_q != '0);
    assign w_pop     = (fifo_cnt_q != '0) & bus.res_ready;
    // Frames in flight plus queued results may never exceed the FIFO depth.
    assign w_credit  = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(RES_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            frame_q       <= '0;
            in_ready_q    <= 1'b0;
            fft_valid_q   <= 1'b0;
            err_framing_q <= 1'b0;
        end else begin
            fft_valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (w_accept) begin
                        frame_q[cnt_q] <= bus.in_data;
                        if (cnt_q == C_LAST) begin
                            state_q    <= HOLD;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            if (!bus.in_last) err_framing_q <= 1'b1;
                        end else if (bus.in_last) begin
                            cnt_q         <= '0;
                            err_framing_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (w_credit) begin
                        state_q     <= ISSUE;
                        fft_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q  <= '0;
            tagq_wr_q  <= '0;
            tagq_rd_q  <= '0;
            outst_q    <= '0;
            err_done_q <= 1'b0;
            for (int i = 0; i < RES_DEPTH; i++) tagq_q[i] <= '0;
        end else begin
            if (w_issue) begin
                tagq_q[tagq_wr_q] <= tag_cnt_q;
                tagq_wr_q         <= tagq_wr_q + 1'b1;
                tag_cnt_q         <= tag_cnt_q + 8'd1;
            end
            if (w_timeout) begin
                // Flush: only a frame launching this very cycle stays in flight.
                tagq_rd_q <= tagq_wr_q;
                outst_q   <= w_issue ? CW'(1) : '0;
            end else begin
                if (w_done_ok) tagq_rd_q <= tagq_rd_q + 1'b1;
                if (w_issue && !w_done_ok)      outst_q <= outst_q + 1'b1;
                else if (!w_issue && w_done_ok) outst_q <= outst_q - 1'b1;
            end
            if (bus.done && (outst_q == '0)) err_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (w_done_ok) begin
                fifo_q[fifo_wr_q] <= {tagq_q[tagq_rd_q], bus.freq_in};
                fifo_wr_q         <= fifo_wr_q + 1'b1;
            end
            if (w_pop) fifo_rd_q <= fifo_rd_q + 1'b1;
            if (w_done_ok && !w_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!w_done_ok && w_pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

`ifdef ANALYSIS_FRAME_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q;
    logic          err_timeout_q;

    // Counter starts on the launch cycle so it trips TIMEOUT cycles after fft_valid.
    assign w_timeout = !bus.done && (outst_q != '0) && (wd_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else if (bus.done || w_timeout) begin
            wd_q <= '0;
            if (w_timeout) err_timeout_q <= 1'b1;
        end else if ((outst_q != '0) || w_issue) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign bus.err_timeout = err_timeout_q;
`else
    assign w_timeout       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.fft_valid   = fft_valid_q;
    assign bus.fft_bus     = frame_q;
    assign bus.res_valid   = (fifo_cnt_q != '0);
    assign bus.res_tag     = fifo_q[fifo_rd_q][11:4];
    assign bus.res_freq    = fifo_q[fifo_rd_q][3:0];
    assign bus.err_framing = err_framing_q;
    assign bus.err_done    = err_done_q;
endmodule
`default_nettype wire

// File: tb/tb_analysis_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_analysis_frame_ctrl
// Description : Self-checking bench for analysis_frame_ctrl with a behavioural
//               argmax pipeline and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_analysis_frame_ctrl;
    localparam int PIPE_LAT = 6;
    localparam int TIMEOUT  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    analysis_frame_ctrl_if bus ();

    analysis_frame_ctrl #(
        .NPT(16), .PIPE_LAT(PIPE_LAT), .RES_DEPTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int                ntests = 0;
    int                nfail  = 0;
    int                pipe_mode = 0;   // 0: argmax, 1: constant 9, 2: silent
    logic              man_done = 1'b0;
    logic [3:0]        man_freq = 4'd0;
    logic [4:0]        pstage [PIPE_LAT];
    int                fv_count;
    logic [15:0][31:0] frame;
    logic [11:0]       exp_q [$];
    logic [7:0]        tag_m;

    // Winning bin = largest |re|+|im|, lowest index on ties.
    function automatic logic [3:0] argmax(input logic [15:0][31:0] f);
        int best, re, im, m;
        logic [3:0] idx;
        best = -1;
        idx  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            re = $signed(f[k][31:16]);
            im = $signed(f[k][15:0]);
            m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
            if (m > best) begin
                best = m;
                idx  = 4'(k);
            end
        end
        return idx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pstage[i] <= '0;
            fv_count <= 0;
        end else begin
            pstage[0] <= {bus.fft_valid && (pipe_mode != 2),
                          (pipe_mode == 1) ? 4'd9 : argmax(bus.fft_bus)};
            for (int i = 1; i < PIPE_LAT; i++) pstage[i] <= pstage[i-1];
            if (bus.fft_valid) fv_count <= fv_count + 1;
        end
    end

    assign bus.done    = pstage[PIPE_LAT-1][4] | man_done;
    assign bus.freq_in = man_done ? man_freq : pstage[PIPE_LAT-1][3:0];

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        tag_m = 8'd0;
        @(negedge clk);
    endtask

    task automatic send_sample(input logic [31:0] d, input logic last, input int gap);
        int waitc;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        waitc = 0;
        while (!bus.in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            ntests++; nfail++;
            $display("FAIL in_ready_wait: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waitc);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic send_frame(input int nsamp, input int last_at, input int maxgap);
        for (int k = 0; k < 16; k++) frame[k] = $urandom;
        for (int k = 0; k < nsamp; k++)
            send_sample(frame[k], (k == last_at), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ntests++;
        if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready: got %0b, expected 0", bus.in_ready); end
        ntests++;
        if ({bus.fft_valid, bus.res_valid, bus.err_framing, bus.err_done, bus.err_timeout} !== 5'b0) begin
            nfail++; $display("FAIL reset_flags: got %b, expected 00000",
                {bus.fft_valid, bus.res_valid, bus.err_framing, bus.err_done, bus.err_timeout});
        end
        ntests++;
        if (bus.fft_bus !== 512'd0) begin nfail++; $display("FAIL reset_fft_bus: got nonzero, expected 0"); end
        ntests++;
        if ({bus.res_tag, bus.res_freq} !== 12'h000) begin
            nfail++; $display("FAIL reset_result: got %h, expected 000", {bus.res_tag, bus.res_freq});
        end
        rst_n = 1'b1;
        @(negedge clk);
        ntests++;
        if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL release_in_ready: got %0b, expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int n;
        pipe_mode = 1;
        do_reset();
        send_frame(16, 15, 0);
        n = 0;
        while (!bus.fft_valid && n < 10) begin @(negedge clk); n++; end
        ntests++;
        if (n != 1) begin nfail++; $display("FAIL basic_launch_latency: got %0d, expected 1", n); end
        ntests++;
        if (bus.fft_bus[5*32 +: 32] !== frame[5]) begin
            nfail++; $display("FAIL basic_slot5: got %h, expected %h", bus.fft_bus[5*32 +: 32], frame[5]);
        end
        ntests++;
        if (bus.fft_bus !== frame) begin nfail++; $display("FAIL basic_fft_bus: frame buffer differs from inputs"); end
        n = 0;
        while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
        ntests++;
        if (n != 7) begin nfail++; $display("FAIL basic_result_latency: got %0d, expected 7", n); end
        ntests++;
        if ({bus.res_tag, bus.res_freq} !== {8'd0, 4'd9}) begin
            nfail++; $display("FAIL basic_result: got tag %0d freq %0d, expected tag 0 freq 9", bus.res_tag, bus.res_freq);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        ntests++;
        if (bus.res_valid !== 1'b0) begin nfail++; $display("FAIL basic_pop: res_valid=%0b, expected 0", bus.res_valid); end
    endtask

    task automatic test_backpressure();
        int n, got;
        pipe_mode = 0;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send_frame(16, 15, 0);
            exp_q.push_back({tag_m, argmax(frame)});
            tag_m++;
        end
        repeat (10) @(negedge clk);
        ntests++;
        if (fv_count != 4) begin nfail++; $display("FAIL bp_launches: got %0d, expected 4", fv_count); end
        ntests++;
        if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready: got %0b, expected 0", bus.in_ready); end
        ntests++;
        if (bus.res_valid !== 1'b1 || {bus.res_tag, bus.res_freq} !== exp_q[0]) begin
            nfail++; $display("FAIL bp_head: got valid %0b %h, expected valid 1 %h", bus.res_valid, {bus.res_tag, bus.res_freq}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n = 0;
        while (fv_count < 5 && n < 10) begin @(negedge clk); n++; end
        ntests++;
        if (fv_count != 5) begin nfail++; $display("FAIL bp_resume: launches %0d, expected 5", fv_count); end
        bus.res_ready = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 100) begin
            if (bus.res_valid) begin
                ntests++;
                if ({bus.res_tag, bus.res_freq} !== exp_q[0]) begin
                    nfail++; $display("FAIL bp_order: got %h, expected %h", {bus.res_tag, bus.res_freq}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                got++;
            end
            @(negedge clk); n++;
        end
        bus.res_ready = 1'b0;
        ntests++;
        if (got != 4) begin nfail++; $display("FAIL bp_drain: got %0d results, expected 4", got); end
    endtask

    task automatic test_framing();
        int n;
        pipe_mode = 0;
        do_reset();
        send_frame(10, 9, 0);
        repeat (20) @(negedge clk);
        ntests++;
        if (fv_count != 0 || bus.err_framing !== 1'b1) begin
            nfail++; $display("FAIL frame_short: launches %0d err %0b, expected 0 and 1", fv_count, bus.err_framing);
        end
        send_frame(16, 15, 0);
        exp_q.push_back({tag_m, argmax(frame)});
        tag_m++;
        n = 0;
        while (!bus.res_valid && n < 30) begin @(negedge clk); n++; end
        ntests++;
        if (bus.res_valid !== 1'b1 || {bus.res_tag, bus.res_freq} !== exp_q[0]) begin
            nfail++; $display("FAIL frame_recover: got valid %0b %h, expected valid 1 %h", bus.res_valid, {bus.res_tag, bus.res_freq}, exp_q[0]);
        end
        ntests++;
        if (bus.err_framing !== 1'b1) begin nfail++; $display("FAIL frame_sticky: got %0b, expected 1", bus.err_framing); end
        do_reset();
        send_frame(16, -1, 0);
        n = 0;
        while (!bus.fft_valid && n < 10) begin @(negedge clk); n++; end
        ntests++;
        if (bus.fft_valid !== 1'b1 || bus.err_framing !== 1'b1) begin
            nfail++; $display("FAIL frame_nolast: fft_valid %0b err %0b, expected 1 and 1", bus.fft_valid, bus.err_framing);
        end
    endtask

    task automatic test_spurious_done();
        pipe_mode = 2;
        do_reset();
        man_freq = 4'($urandom);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        ntests++;
        if (bus.err_done !== 1'b1 || bus.res_valid !== 1'b0) begin
            nfail++; $display("FAIL spurious_done: err %0b valid %0b, expected 1 and 0", bus.err_done, bus.res_valid);
        end
    endtask

    task automatic test_coincide();
        logic [3:0] f1, f2;
        pipe_mode = 2;
        do_reset();
        send_frame(16, 15, 0);
        send_frame(16, 15, 0);
        @(negedge clk);
        ntests++;
        if (bus.fft_valid !== 1'b1) begin nfail++; $display("FAIL coin_launch: fft_valid %0b, expected 1", bus.fft_valid); end
        f1 = 4'($urandom);
        man_freq = f1; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        ntests++;
        if (bus.res_valid !== 1'b1 || {bus.res_tag, bus.res_freq} !== {8'd0, f1}) begin
            nfail++; $display("FAIL coin_result: got valid %0b %h, expected valid 1 %h", bus.res_valid, {bus.res_tag, bus.res_freq}, {8'd0, f1});
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        ntests++;
        if (bus.res_valid !== 1'b0) begin nfail++; $display("FAIL coin_single: res_valid %0b, expected 0", bus.res_valid); end
        f2 = 4'($urandom);
        man_freq = f2; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        ntests++;
        if ({bus.res_valid, bus.err_done, bus.res_tag, bus.res_freq} !== {1'b1, 1'b0, 8'd1, f2}) begin
            nfail++; $display("FAIL coin_second: got valid %0b err %0b %h, expected valid 1 err 0 %h",
                bus.res_valid, bus.err_done, {bus.res_tag, bus.res_freq}, {8'd1, f2});
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        ntests++;
        if (bus.err_done !== 1'b1) begin nfail++; $display("FAIL coin_drained: err_done %0b, expected 1", bus.err_done); end
    endtask

    task automatic test_random_stream();
        int n, got;
        logic r;
        pipe_mode = 0;
        do_reset();
        got = 0; n = 0;
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    send_frame(16, 15, 3);
                    exp_q.push_back({tag_m, argmax(frame)});
                    tag_m++;
                end
            end
            begin
                while (got < 8 && n < 3000) begin
                    r = 1'($urandom_range(1, 0));
                    bus.res_ready = r;
                    if (bus.res_valid && r) begin
                        ntests++;
                        if (exp_q.size() == 0 || {bus.res_tag, bus.res_freq} !== exp_q[0]) begin
                            nfail++; $display("FAIL rand_result: got %h, expected %h (queued %0d)",
                                {bus.res_tag, bus.res_freq}, (exp_q.size() != 0) ? exp_q[0] : 12'hxxx, exp_q.size());
                        end
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got++;
                    end
                    @(negedge clk); n++;
                end
            end
        join
        bus.res_ready = 1'b0;
        ntests++;
        if (got != 8) begin nfail++; $display("FAIL rand_count: got %0d results, expected 8", got); end
    endtask

    task automatic test_timeout();
        int n;
        pipe_mode = 2;
        do_reset();
        send_frame(16, 15, 0);
        n = 0;
        while (!bus.fft_valid && n < 10) begin @(negedge clk); n++; end
`ifdef ANALYSIS_FRAME_CTRL_TIMEOUT_EN
        n = 0;
        while (!bus.err_timeout && n < 100) begin @(negedge clk); n++; end
        ntests++;
        if (n != TIMEOUT) begin nfail++; $display("FAIL timeout_latency: got %0d, expected %0d", n, TIMEOUT); end
        send_frame(16, 15, 0);
        n = 0;
        while (!bus.fft_valid && n < 10) begin @(negedge clk); n++; end
        ntests++;
        if (bus.fft_valid !== 1'b1) begin nfail++; $display("FAIL timeout_relaunch: fft_valid %0b, expected 1", bus.fft_valid); end
        man_freq = 4'd3; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        ntests++;
        if ({bus.res_valid, bus.err_done, bus.res_tag} !== {1'b1, 1'b0, 8'd1}) begin
            nfail++; $display("FAIL timeout_result: got valid %0b err %0b tag %0d, expected 1 0 1", bus.res_valid, bus.err_done, bus.res_tag);
        end
`else
        repeat (TIMEOUT + 10) @(negedge clk);
        ntests++;
        if (bus.err_timeout !== 1'b0) begin nfail++; $display("FAIL no_timeout: err_timeout %0b, expected 0", bus.err_timeout); end
        man_freq = 4'd3; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        ntests++;
        if ({bus.res_valid, bus.err_done, bus.res_tag, bus.res_freq} !== {1'b1, 1'b0, 8'd0, 4'd3}) begin
            nfail++; $display("FAIL late_done: got valid %0b err %0b %h, expected 1 0 003",
                bus.res_valid, bus.err_done, {bus.res_tag, bus.res_freq});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_framing();
        test_spurious_done();
        test_coincide();
        test_random_stream();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
